rr_mux_arbiter: RTL and testbench

//   Arbitrates round-robin between four requesters (a,b,c,d) that share one
//   4:1 select datapath. Drives the select lines {s1,s2} of the shared mux.

---
 rtl/rr_mux_pkg.sv | 38 +++
 rtl/mux4_w.sv | 29 ++
 rtl/rr_mux_arbiter.sv | 80 ++++++++
 tb/tb_rr_mux_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_mux_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    // Select encodings shared by the arbiter and the word mux
    localparam logic [SEL_W-1:0] SEL_A = 2'b00;
    localparam logic [SEL_W-1:0] SEL_B = 2'b01;
    localparam logic [SEL_W-1:0] SEL_C = 2'b10;
    localparam logic [SEL_W-1:0] SEL_D = 2'b11;

    // Output slot occupancy
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // First set request bit scanning last+1, last+2, ... (mod N_REQ).
    // Returns last when no request is set; callers gate on |req anyway.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux4_w.sv
// Combinational 4:1 word mux, select encoding from rr_mux_pkg.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows sel directly.
module mux4_w
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic [WIDTH-1:0] y
);

    // Route the selected requester word to the output
    always_comb begin
        y = in_a;
        case (sel)
            SEL_A:   y = in_a;
            SEL_B:   y = in_b;
            SEL_C:   y = in_c;
            SEL_D:   y = in_d;
            default: y = in_a;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over four requesters feeding one registered output slot.
// Latency: 1 cycle from gnt to y_valid; one word per cycle when y_ready=1.
// Backpressure: a full slot with y_ready=0 blocks all grants; y_data holds.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic [N_REQ-1:0] gnt,
    input  logic             y_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic [SEL_W-1:0] sel
);

    slot_state_t      state;
    slot_state_t      state_nxt;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] winner;
    logic [WIDTH-1:0] mux_y;
    logic             load;

    assign y_valid = (state == SLOT_FULL);

    // Slot can take a word when empty or being drained this cycle; reset blocks it
    assign load   = (|req) && (!y_valid || y_ready) && !rst;
    assign winner = rr_pick(req, last);
    assign gnt    = load ? (N_REQ'(1) << winner) : '0;

    mux4_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel  (winner),
        .in_a (in_a),
        .in_b (in_b),
        .in_c (in_c),
        .in_d (in_d),
        .y    (mux_y)
    );

    // Slot occupancy next-state: fill on load, drain when read without refill
    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: if (load) state_nxt = SLOT_FULL;
            SLOT_FULL:  if (y_ready && !load) state_nxt = SLOT_EMPTY;
            default:    state_nxt = SLOT_EMPTY;
        endcase
    end

    // Slot occupancy register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winning word and advance the round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            y_data <= '0;
            sel    <= SEL_A;
            last   <= SEL_D;
        end else if (load) begin
            y_data <= mux_y;
            sel    <= winner;
            last   <= winner;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] in_a, in_b, in_c, in_d;
    logic [3:0] gnt;
    logic       y_ready;
    logic       y_valid;
    logic [7:0] y_data;
    logic [1:0] sel;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .in_a    (in_a),
        .in_b    (in_b),
        .in_c    (in_c),
        .in_d    (in_d),
        .gnt     (gnt),
        .y_ready (y_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (abstract slot + pointer) -------------
    bit       m_valid;
    bit [7:0] m_data;
    int       m_sel;
    int       m_last;

    function automatic bit [7:0] word_of(input int i);
        case (i)
            0: return in_a;
            1: return in_b;
            2: return in_c;
            default: return in_d;
        endcase
    endfunction

    // Winner index per the rotating scan, or -1 if nothing can be granted
    function automatic int model_winner();
        if (rst || req == 4'b0000 || (m_valid && !y_ready)) return -1;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit [3:0] model_gnt();
        int w;
        bit [3:0] g;
        w = model_winner();
        g = 4'b0000;
        if (w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    initial begin
        m_valid = 0; m_data = 0; m_sel = 0; m_last = 3;
    end

    always @(posedge clk) begin
        int w;
        w = model_winner();
        if (rst) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_last = 3;
        end else if (w >= 0) begin
            m_valid = 1; m_data = word_of(w); m_sel = w; m_last = w;
        end else if (m_valid && y_ready) begin
            m_valid = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests -------------------------------------------------
    task automatic test_reset();
        rst = 1; req = 4'b1111; y_ready = 0;
        in_a = 8'h11; in_b = 8'h22; in_c = 8'h33; in_d = 8'h44;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL reset_gnt cycle %0d: got %b want 0000", i, gnt);
            end
            next_cycle();
        end
        checks++;
        if (y_valid !== 1'b0 || y_data !== 8'h00 || sel !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%b want v=0 d=00 s=00",
                     y_valid, y_data, sel);
        end
    endtask

    task automatic test_single();
        rst = 0; req = 4'b0010; in_b = 8'hA5; y_ready = 1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL single_gnt: got %b want 0010", gnt);
        end
        next_cycle();
        req = 4'b0000;
        checks++;
        if (y_valid !== 1'b1 || y_data !== 8'hA5 || sel !== 2'b01) begin
            errors++;
            $display("FAIL single_out: got v=%b d=%h s=%b want v=1 d=a5 s=01",
                     y_valid, y_data, sel);
        end
    endtask

    task automatic test_back_to_back();
        bit [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int       exp_s [5] = '{0, 1, 2, 3, 0};
        bit [7:0] exp_d;
        // Restart the pointer so the rotation begins at a
        rst = 1; req = 4'b0000;
        next_cycle();
        rst = 0; req = 4'b1111; y_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom);
            in_c = 8'($urandom); in_d = 8'($urandom);
            exp_d = word_of(exp_s[i]);
            @(negedge clk);
            checks++;
            if (gnt !== exp_g[i]) begin
                errors++;
                $display("FAIL rotate_gnt step %0d: got %b want %b", i, gnt, exp_g[i]);
            end
            next_cycle();
            checks++;
            if (y_valid !== 1'b1 || y_data !== exp_d || sel !== 2'(exp_s[i])) begin
                errors++;
                $display("FAIL rotate_out step %0d: got v=%b d=%h s=%b want v=1 d=%h s=%0d",
                         i, y_valid, y_data, sel, exp_d, exp_s[i]);
            end
        end
    endtask

    task automatic test_stall();
        bit [7:0] held;
        held = y_data;
        y_ready = 0; req = 4'b0100; in_c = 8'h5C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000 || y_valid !== 1'b1 || y_data !== held) begin
                errors++;
                $display("FAIL stall step %0d: got g=%b v=%b d=%h want g=0000 v=1 d=%h",
                         i, gnt, y_valid, y_data, held);
            end
            next_cycle();
        end
        y_ready = 1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL stall_release_gnt: got %b want 0100", gnt);
        end
        next_cycle();
        checks++;
        if (y_valid !== 1'b1 || y_data !== 8'h5C || sel !== 2'b10) begin
            errors++;
            $display("FAIL stall_release_out: got v=%b d=%h s=%b want v=1 d=5c s=10",
                     y_valid, y_data, sel);
        end
    endtask

    task automatic test_wrap();
        // Park the pointer on a, then offer a and d together
        req = 4'b0001; y_ready = 1; in_a = 8'hA0; in_d = 8'hD0;
        next_cycle();
        req = 4'b1001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: got %b want 1000", gnt);
        end
        next_cycle();
        checks++;
        if (y_data !== 8'hD0 || sel !== 2'b11) begin
            errors++;
            $display("FAIL wrap_first_out: got d=%h s=%b want d=d0 s=11", y_data, sel);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_second: got %b want 0001", gnt);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        // Slot is full here with the word from a
        rst = 1; req = 4'b1111; y_ready = 0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || y_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_gnt: got g=%b v=%b want g=0000 v=1", gnt, y_valid);
        end
        next_cycle();
        checks++;
        if (y_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: got %b want 0", y_valid);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_first_gnt: got %b want 0001", gnt);
        end
        next_cycle();
    endtask

    task automatic test_random();
        bit [3:0] exp_g;
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(49) == 0);
            req     = 4'($urandom);
            if ($urandom_range(5) == 0) req = 4'b0000;
            y_ready = ($urandom_range(3) != 0);
            in_a = 8'($urandom); in_b = 8'($urandom);
            in_c = 8'($urandom); in_d = 8'($urandom);
            @(negedge clk);
            exp_g = model_gnt();
            checks++;
            if (gnt !== exp_g) begin
                errors++;
                $display("FAIL random_gnt iter %0d: got %b want %b", i, gnt, exp_g);
            end
            next_cycle();
            checks++;
            if (y_valid !== m_valid || y_data !== m_data || sel !== 2'(m_sel)) begin
                errors++;
                $display("FAIL random_out iter %0d: got v=%b d=%h s=%b want v=%b d=%h s=%0d",
                         i, y_valid, y_data, sel, m_valid, m_data, m_sel);
            end
        end
    endtask

    initial begin
        rst = 1; req = 4'b0000; y_ready = 0;
        in_a = 8'h00; in_b = 8'h00; in_c = 8'h00; in_d = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
